// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constant control words for the RV32I pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

  typedef struct packed {
    logic en_pc;
    logic en_fd;
    logic en_de;
    logic en_em;
    logic en_mw;
    logic clr_fd;
    logic clr_de;
    logic clr_em;
    logic clr_mw;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RESET = '{
    en_pc: 1'b0, en_fd: 1'b0, en_de: 1'b0, en_em: 1'b0, en_mw: 1'b0,
    clr_fd: 1'b1, clr_de: 1'b1, clr_em: 1'b1, clr_mw: 1'b1
  };

  localparam stage_ctrl_t CTRL_RUN = '{
    en_pc: 1'b1, en_fd: 1'b1, en_de: 1'b1, en_em: 1'b1, en_mw: 1'b1,
    clr_fd: 1'b0, clr_de: 1'b0, clr_em: 1'b0, clr_mw: 1'b0
  };

endpackage

// File: rtl/pipe_hazard_ctrl_mc_seq.sv
// Multi-cycle EX sequencer: holds a mul/memcpy in EX for its declared cycle count.
module mc_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mc_start_e,
  input  logic [CNTW-1:0] mc_cycles,
  input  logic            freeze,
  output logic            mc_hold,
  output logic            mc_busy
);

  mc_state_t       state_r;
  logic [CNTW-1:0] cnt_r;
  logic            start_s;

  assign start_s = mc_start_e && (mc_cycles >= CNTW'(2'd2));

  // Hold EX while a qualifying op enters, or while the countdown has cycles left.
  always_comb begin
    mc_hold = 1'b0;
    case (state_r)
      IDLE:    mc_hold = start_s;
      BUSY:    mc_hold = (cnt_r != {CNTW{1'b0}});
      default: mc_hold = 1'b0;
    endcase
  end

  assign mc_busy = (state_r == BUSY);

  // FSM and countdown; the entry cycle and release cycle account for the "- 2".
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNTW{1'b0}};
    end else if (freeze) begin
      state_r <= state_r;
      cnt_r   <= cnt_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r <= BUSY;
            cnt_r   <= mc_cycles - CNTW'(2'd2);
          end else begin
            state_r <= IDLE;
            cnt_r   <= cnt_r;
          end
        end
        BUSY: begin
          if (cnt_r != {CNTW{1'b0}}) begin
            state_r <= BUSY;
            cnt_r   <= cnt_r - CNTW'(1'b1);
          end else begin
            state_r <= IDLE;
            cnt_r   <= cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNTW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use compare plus prioritised per-stage en/clr mux.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REGW = 5,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rs1_d,
  input  logic [REGW-1:0] rs2_d,
  input  logic [REGW-1:0] rd_e,
  input  logic            memread_e,
  input  logic            pcsrc_e,
  input  logic            mc_start_e,
  input  logic [CNTW-1:0] mc_cycles,
  input  logic            dmem_wait,
  output logic            en_pc,
  output logic            en_fd,
  output logic            en_de,
  output logic            en_em,
  output logic            en_mw,
  output logic            clr_fd,
  output logic            clr_de,
  output logic            clr_em,
  output logic            clr_mw,
  output logic            mc_busy
);

  stage_ctrl_t ctrl_s;
  logic        lw_hazard_s;
  logic        mc_hold_s;
  logic        mc_busy_s;

  mc_seq #(.CNTW(CNTW)) u_mc_seq (
    .clk        (clk),
    .reset      (reset),
    .mc_start_e (mc_start_e),
    .mc_cycles  (mc_cycles),
    .freeze     (dmem_wait),
    .mc_hold    (mc_hold_s),
    .mc_busy    (mc_busy_s)
  );

  assign lw_hazard_s = memread_e && (rd_e != {REGW{1'b0}}) &&
                       ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Priority mux: memory wait > multi-cycle hold > taken branch > load-use.
  always_comb begin
    ctrl_s = CTRL_RUN;
    if (!reset) begin
      ctrl_s = CTRL_RESET;
    end else if (dmem_wait) begin
      ctrl_s.en_pc  = 1'b0;
      ctrl_s.en_fd  = 1'b0;
      ctrl_s.en_de  = 1'b0;
      ctrl_s.en_em  = 1'b0;
      ctrl_s.clr_mw = 1'b1;
    end else if (mc_hold_s) begin
      ctrl_s.en_pc  = 1'b0;
      ctrl_s.en_fd  = 1'b0;
      ctrl_s.en_de  = 1'b0;
      ctrl_s.clr_em = 1'b1;
    end else if (pcsrc_e) begin
      // The ID instruction is squashed, so a load-use stall would only delay the target fetch.
      ctrl_s.clr_fd = 1'b1;
      ctrl_s.clr_de = 1'b1;
    end else if (lw_hazard_s) begin
      ctrl_s.en_pc  = 1'b0;
      ctrl_s.en_fd  = 1'b0;
      ctrl_s.clr_de = 1'b1;
    end else begin
      ctrl_s = CTRL_RUN;
    end
  end

  assign en_pc   = ctrl_s.en_pc;
  assign en_fd   = ctrl_s.en_fd;
  assign en_de   = ctrl_s.en_de;
  assign en_em   = ctrl_s.en_em;
  assign en_mw   = ctrl_s.en_mw;
  assign clr_fd  = ctrl_s.clr_fd;
  assign clr_de  = ctrl_s.clr_de;
  assign clr_em  = ctrl_s.clr_em;
  assign clr_mw  = ctrl_s.clr_mw;
  assign mc_busy = reset && mc_busy_s;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  // Expected words ordered {en_pc,en_fd,en_de,en_em,en_mw,clr_fd,clr_de,clr_em,clr_mw}
  localparam logic [8:0] E_RUN = 9'b11111_0000;
  localparam logic [8:0] E_RST = 9'b00000_1111;
  localparam logic [8:0] E_LW  = 9'b00111_0100;
  localparam logic [8:0] E_BR  = 9'b11111_1100;
  localparam logic [8:0] E_MC  = 9'b00011_0010;
  localparam logic [8:0] E_DW  = 9'b00001_0001;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic       memread_e, pcsrc_e, mc_start_e, dmem_wait;
  logic [5:0] mc_cycles;
  logic       en_pc, en_fd, en_de, en_em, en_mw;
  logic       clr_fd, clr_de, clr_em, clr_mw, mc_busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       mr, pc, mcs, dw;
    logic [5:0] mcc;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [12];

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
    .memread_e(memread_e), .pcsrc_e(pcsrc_e), .mc_start_e(mc_start_e),
    .mc_cycles(mc_cycles), .dmem_wait(dmem_wait),
    .en_pc(en_pc), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
    .clr_fd(clr_fd), .clr_de(clr_de), .clr_em(clr_em), .clr_mw(clr_mw),
    .mc_busy(mc_busy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic pc, input logic mcs,
                       input logic [5:0] mcc, input logic dw);
    rs1_d = rs1; rs2_d = rs2; rd_e = rd;
    memread_e = mr; pcsrc_e = pc; mc_start_e = mcs; mc_cycles = mcc; dmem_wait = dw;
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge.
  task automatic check(input string name, input logic [8:0] exp, input logic exp_busy);
    logic [8:0] act;
    #3;
    act = {en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw};
    vectors++;
    if (act !== exp || mc_busy !== exp_busy) begin
      miscompares++;
      $display("FAIL %s: ctrl=%b busy=%b, expected ctrl=%b busy=%b", name, act, mc_busy, exp, exp_busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
  endtask

  initial begin
    //            rs1    rs2    rd     mr    pc    mcs   dw    mcc    exp
    tbl[0]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'd0, E_RUN};
    tbl[1]  = '{5'd1,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 6'd0, E_LW};
    tbl[2]  = '{5'd5,  5'd9,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 6'd0, E_LW};
    tbl[3]  = '{5'd0,  5'd3,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 6'd0, E_RUN};
    tbl[4]  = '{5'd5,  5'd5,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 6'd0, E_RUN};
    tbl[5]  = '{5'd6,  5'd7,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 6'd0, E_RUN};
    tbl[6]  = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 6'd0, E_BR};
    tbl[7]  = '{5'd2,  5'd3,  5'd4,  1'b0, 1'b1, 1'b0, 1'b0, 6'd0, E_BR};
    tbl[8]  = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 6'd0, E_DW};
    tbl[9]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 6'd1, E_RUN};
    tbl[10] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 6'd0, E_RUN};
    tbl[11] = '{5'd31, 5'd2,  5'd31, 1'b1, 1'b0, 1'b1, 1'b0, 6'd1, E_LW};

    reset = 1'b0;
    quiet();
    @(posedge clk);
    #1;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 6'($urandom), 1'($urandom));
      check("reset", E_RST, 1'b0);
    end
    reset = 1'b1;
    quiet();
    check("post_reset", E_RUN, 1'b0);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].mr, tbl[i].pc, tbl[i].mcs,
            tbl[i].mcc, tbl[i].dw);
      check($sformatf("vec%0d", i), tbl[i].exp, 1'b0);
    end

    // mc_cycles=4; late mc_cycles change must be ignored
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0);
    check("mc4_c1", E_MC, 1'b0);
    mc_cycles = 6'd1;
    check("mc4_c2", E_MC, 1'b1);
    mc_cycles = 6'd9;
    check("mc4_c3", E_MC, 1'b1);
    check("mc4_release", E_RUN, 1'b1);
    quiet();
    check("mc4_after", E_RUN, 1'b0);

    // mc_cycles=1: no stall
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0);
    check("mc1_c1", E_RUN, 1'b0);
    quiet();
    check("mc1_after", E_RUN, 1'b0);

    // mc_cycles=4 with two dmem_wait cycles inside
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0);
    check("mcdw_c1", E_MC, 1'b0);
    check("mcdw_c2", E_MC, 1'b1);
    dmem_wait = 1'b1;
    check("mcdw_w1", E_DW, 1'b1);
    check("mcdw_w2", E_DW, 1'b1);
    dmem_wait = 1'b0;
    check("mcdw_c3", E_MC, 1'b1);
    check("mcdw_release", E_RUN, 1'b1);
    quiet();
    check("mcdw_after", E_RUN, 1'b0);

    // Reset in second BUSY cycle discards the op
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0);
    check("mcrst_c1", E_MC, 1'b0);
    reset = 1'b0;
    check("mcrst_reset", E_RST, 1'b0);
    reset = 1'b1;
    quiet();
    check("mcrst_after1", E_RUN, 1'b0);
    check("mcrst_after2", E_RUN, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32I pipeline.
- Drives per-stage enable and synchronous-clear controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sources: load-use hazards, taken branches/jumps, data-memory wait, and multi-cycle EX operations (mul, memcpy).
- Contains a small FSM and counter that hold a multi-cycle op in EX for its declared cycle count.

Parameters:
- REGW, 5, register-index width.
- CNTW, 6, width of mc_cycles and the internal countdown.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- rs1_d  input  REGW  rs1 index of instruction in ID.
- rs2_d  input  REGW  rs2 index of instruction in ID.
- rd_e  input  REGW  rd index of instruction in EX.
- memread_e  input  1  instruction in EX is a load.
- pcsrc_e  input  1  taken branch/jump resolved in EX.
- mc_start_e  input  1  instruction in EX is multi-cycle; held high while it sits in EX.
- mc_cycles  input  CNTW  total EX residency N for that op.
- dmem_wait  input  1  data memory not ready; MEM must hold.
- en_pc, en_fd, en_de, en_em, en_mw  output  1 each  register load enables.
- clr_fd, clr_de, clr_em, clr_mw  output  1 each  synchronous bubble insert; takes priority over en in the stage register.
- mc_busy  output  1  FSM in BUSY.

Behaviour:
- Reset (reset==0 at a clk edge): state := IDLE, cnt := 0.
- While reset==0, outputs are forced: all en_* = 0, all clr_* = 1, mc_busy = 0.
- Outputs are combinational from state, cnt and inputs (zero latency). State and cnt are registered.
- lw_hazard = memread_e & (rd_e != 0) & ((rd_e == rs1_d) | (rd_e == rs2_d)). x0 never causes a hazard.
- mc_hold = (IDLE & mc_start_e & mc_cycles >= 2) | (BUSY & cnt != 0).
- Priority, highest first:
  1. dmem_wait: en_pc = en_fd = en_de = en_em = 0; clr_mw = 1; other clr = 0. FSM and cnt frozen.
  2. mc_hold: en_pc = en_fd = en_de = 0; clr_em = 1; en_mw = 1.
  3. pcsrc_e: clr_fd = clr_de = 1; all en = 1. Suppresses lw_hazard, because the ID instruction is squashed and the PC must take the target.
  4. lw_hazard: en_pc = en_fd = 0; clr_de = 1; other en = 1.
  5. Default: all en = 1, all clr = 0.
- FSM (advances only when dmem_wait == 0):
  - IDLE -> BUSY when mc_start_e & mc_cycles >= 2; cnt := mc_cycles - 2.
  - BUSY & cnt != 0: cnt := cnt - 1.
  - BUSY & cnt == 0: release cycle. No mc stall; EX advances at this edge; -> IDLE.
  - mc_start_e is ignored in BUSY, so the release cycle never retriggers.
- mc_cycles of 0 or 1: no stall, FSM stays IDLE.
- Total EX residency is exactly N cycles, excluding dmem_wait cycles.
- mc_busy = (state == BUSY).
- Reset asserted mid-BUSY: returns to IDLE next edge and the counter is discarded.
- mc_cycles is sampled only on the IDLE->BUSY transition; later changes have no effect.

Decomposition:
- Package pipe_ctrl_pkg:
  - mc_state_t enum {IDLE, BUSY}.
  - Struct stage_ctrl_t bundling the en/clr fields.
  - Constant CTRL_RESET (all en 0, all clr 1).
  - Constant CTRL_RUN (all en 1, all clr 0).
- Sub-module mc_seq: FSM plus countdown. Inputs: clk, reset, mc_start_e, mc_cycles, freeze (= dmem_wait). Outputs: mc_hold, mc_busy.
- Top level holds the hazard compare and the priority mux.

Test Plan:
- Reset held low 3 cycles with random inputs -> en_* all 0, clr_* all 1, mc_busy 0; first cycle after release with quiet inputs -> all en 1, clr 0.
- Load-use: memread_e=1, rd_e=5, rs2_d=5 -> en_pc=en_fd=0, clr_de=1 for one cycle. Repeat with rd_e=0, rs1_d=0 -> no stall.
- Simultaneous pcsrc_e=1 and lw_hazard -> clr_fd=clr_de=1, en_pc=1 (branch wins, no stall).
- mc_start_e=1, mc_cycles=4 -> en_pc/en_fd/en_de=0 and clr_em=1 for exactly 3 cycles; mc_busy high for cycles 2-4; cycle 4 is the release with all en=1. mc_cycles=1 -> zero stall cycles.
- dmem_wait=1 for 2 cycles in the middle of the mc_cycles=4 op -> stall extends to 5 cycles; clr_mw=1 during the wait; cnt is not decremented.
- reset=0 asserted in the 2nd BUSY cycle -> IDLE after that edge; with mc_start_e=0 after reset, no further stall.
